// File: rtl/led_pattern_controller.sv
// Command-driven LED pattern sequencer (OFF / BLINK / CHASE / BURST).
// Commands are captured with a ready/valid handshake and applied on the next prescaler tick.
module led_pattern_controller #(
  parameter int NUM_LEDS    = 4,
  parameter int TICK_LIMIT  = 49_999_999,
  parameter int BURST_COUNT = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd_mode,
  input  logic [3:0]          i_cmd_rate,
  output logic                o_cmd_ready,
  output logic [1:0]          o_mode,
  output logic [NUM_LEDS-1:0] o_led
);

  // phase  | meaning
  // PH_ON  | burst LEDs lit
  // PH_OFF | burst LEDs dark between pulses
  // PH_GAP | dark pause after the last pulse of a burst
  typedef enum logic [1:0] {PH_ON, PH_OFF, PH_GAP} phase_t;

  localparam int PW = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;
  localparam int BW = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_CHASE = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  logic [PW-1:0]       presc_q, presc_d;
  logic                pend_q, pend_d;
  logic [1:0]          pend_mode_q, pend_mode_d;
  logic [3:0]          pend_rate_q, pend_rate_d;
  logic [1:0]          mode_q, mode_d;
  logic [3:0]          rate_q, rate_d;
  logic [3:0]          step_cnt_q, step_cnt_d;
  logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                gap_cnt_q, gap_cnt_d;
  phase_t              phase_q, phase_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  logic tick;
  logic accept;
  logic apply;
  logic burst_last;

  assign tick       = (presc_q == PW'(TICK_LIMIT));
  assign accept     = i_cmd_valid & ~pend_q;
  // pend_q only rises the cycle after acceptance, so a tick on the accept cycle never applies it
  assign apply      = tick & pend_q;
  assign burst_last = (burst_cnt_q == BW'(BURST_COUNT - 1));
  assign presc_d    = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    pend_rate_d = pend_rate_q;
    mode_d      = mode_q;
    rate_d      = rate_q;
    step_cnt_d  = step_cnt_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    phase_d     = phase_q;
    led_d       = led_q;

    if (accept) begin
      pend_d      = 1'b1;
      pend_mode_d = i_cmd_mode;
      pend_rate_d = i_cmd_rate;
    end

    if (apply) begin
      pend_d      = 1'b0;
      mode_d      = pend_mode_q;
      rate_d      = pend_rate_q;
      step_cnt_d  = '0;
      burst_cnt_d = '0;
      gap_cnt_d   = 1'b0;
      phase_d     = PH_ON;
      unique case (pend_mode_q)
        MODE_OFF:   led_d = '0;
        MODE_BLINK: led_d = '1;
        MODE_CHASE: led_d = {{(NUM_LEDS-1){1'b0}}, 1'b1};
        default:    led_d = '1;
      endcase
    end else if (tick) begin
      if (step_cnt_q == rate_q) begin
        step_cnt_d = '0;
        unique case (mode_q)
          MODE_OFF:   led_d = led_q;
          MODE_BLINK: led_d = ~led_q;
          MODE_CHASE: led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
          default: begin
            case (phase_q)
              PH_ON: begin
                phase_d = PH_OFF;
                led_d   = '0;
              end
              PH_OFF: begin
                if (burst_last) begin
                  phase_d     = PH_GAP;
                  led_d       = '0;
                  burst_cnt_d = '0;
                end else begin
                  phase_d     = PH_ON;
                  led_d       = '1;
                  burst_cnt_d = burst_cnt_q + 1'b1;
                end
              end
              PH_GAP: begin
                if (gap_cnt_q) begin
                  phase_d   = PH_ON;
                  led_d     = '1;
                  gap_cnt_d = 1'b0;
                end else begin
                  gap_cnt_d = 1'b1;
                end
              end
              default: begin
                phase_d = PH_ON;
                led_d   = '1;
              end
            endcase
          end
        endcase
      end else begin
        step_cnt_d = step_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q     <= '0;
      pend_q      <= 1'b0;
      pend_mode_q <= MODE_OFF;
      pend_rate_q <= '0;
      mode_q      <= MODE_OFF;
      rate_q      <= '0;
      step_cnt_q  <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= 1'b0;
      phase_q     <= PH_ON;
      led_q       <= '0;
    end else begin
      presc_q     <= presc_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      pend_rate_q <= pend_rate_d;
      mode_q      <= mode_d;
      rate_q      <= rate_d;
      step_cnt_q  <= step_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  assign o_cmd_ready = ~pend_q;
  assign o_mode      = mode_q;
  assign o_led       = led_q;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Bench for led_pattern_controller with TICK_LIMIT=1 (tick on every even clock after reset release).
// Expected LED runs are queued by the stimulus; a monitor pops one per LED change.
module tb_led_pattern_controller;

  logic       i_clk       = 1'b0;
  logic       i_rst_n     = 1'b0;
  logic       i_cmd_valid = 1'b0;
  logic [1:0] i_cmd_mode  = 2'd0;
  logic [3:0] i_cmd_rate  = 4'd0;
  logic       o_cmd_ready;
  logic [1:0] o_mode;
  logic [3:0] o_led;

  led_pattern_controller #(
    .NUM_LEDS(4),
    .TICK_LIMIT(1),
    .BURST_COUNT(3)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_mode(i_cmd_mode),
    .i_cmd_rate(i_cmd_rate),
    .o_cmd_ready(o_cmd_ready),
    .o_mode(o_mode),
    .o_led(o_led)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
    int         prev_len;   // clocks the previous value was held; 0 = not checked
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  int         checks  = 0;
  int         errors  = 0;
  int         cyc     = 0;
  int         run_len = 0;
  bit         mon_en  = 1'b0;
  logic [3:0] prev_led = 4'd0;

  // posedges since reset release; posedge n is a tick when n is even
  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cyc <= 0;
    else          cyc <= cyc + 1;

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (!i_rst_n) begin
      prev_led = o_led;
      run_len  = 0;
    end else if (o_led !== prev_led) begin
      if (mon_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change led=%b mode=%0d required no change", o_led, o_mode);
        end else begin
          e = exp_q.pop_front();
          if (o_led !== e.led || o_mode !== e.mode) begin
            errors++;
            $display("FAIL %s led=%b mode=%0d required led=%b mode=%0d",
                     e.tag, o_led, o_mode, e.led, e.mode);
          end
          if (e.prev_len != 0) begin
            checks++;
            if (run_len != e.prev_len) begin
              errors++;
              $display("FAIL %s_hold held=%0d required=%0d", e.tag, run_len, e.prev_len);
            end
          end
        end
      end
      prev_led = o_led;
      run_len  = 1;
    end else begin
      run_len++;
    end
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [3:0] l, input logic [1:0] m, input int n, input string t);
    exp_q.push_back('{led: l, mode: m, prev_len: n, tag: t});
  endfunction

  // Presents a command so that it is accepted on a tick posedge (on_tick=1) or a non-tick one.
  // Returns just after the negedge following acceptance.
  task automatic issue(input logic [1:0] m, input logic [3:0] r, input bit on_tick, input bit hold);
    int guard;
    guard = 0;
    while (((((cyc + 1) % 2) == 0) != on_tick) && guard < 4) begin
      adv(1);
      guard++;
    end
    chk("ready_before_cmd", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_mode  = m;
    i_cmd_rate  = r;
    adv(1);
    if (!hold) i_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string t);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      adv(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", t, exp_q.size());
    end
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge i_clk);
    chk("rst_led", o_led, 0);
    chk("rst_mode", o_mode, 0);
    chk("rst_ready", o_cmd_ready, 1);
    #1 i_rst_n = 1'b1;

    // BLINK rate 0: accept at non-tick posedge 1, apply at tick posedge 2
    push(4'b1111, 2'd1, 0, "blink_apply");
    push(4'b0000, 2'd1, 2, "blink_t1");
    push(4'b1111, 2'd1, 2, "blink_t2");
    push(4'b0000, 2'd1, 2, "blink_t3");
    issue(2'd1, 4'd0, 1'b0, 1'b0);
    mon_en = 1'b1;
    chk("blink_ready_low", o_cmd_ready, 0);
    chk("blink_led_before_tick", o_led, 4'b0000);
    adv(1);
    chk("blink_ready_back", o_cmd_ready, 1);
    chk("blink_mode", o_mode, 1);
    chk("blink_led_applied", o_led, 4'b1111);
    drain("blink");

    // CHASE rate 1: each position held 4 clocks
    push(4'b0001, 2'd2, 0, "chase_apply");
    push(4'b0010, 2'd2, 4, "chase_s1");
    push(4'b0100, 2'd2, 4, "chase_s2");
    push(4'b1000, 2'd2, 4, "chase_s3");
    push(4'b0001, 2'd2, 4, "chase_wrap");
    issue(2'd2, 4'd1, 1'b0, 1'b0);
    mon_en = 1'b1;
    drain("chase");

    // asynchronous reset between clock edges mid-CHASE
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_led", o_led, 0);
    chk("midrst_mode", o_mode, 0);
    chk("midrst_ready", o_cmd_ready, 1);
    adv(3);
    i_rst_n = 1'b1;

    // BURST rate 0: three pulses, 3-step dark stretch (OFF + 2 GAP), then repeat
    push(4'b1111, 2'd3, 0, "burst_apply");
    push(4'b0000, 2'd3, 2, "burst_off1");
    push(4'b1111, 2'd3, 2, "burst_on2");
    push(4'b0000, 2'd3, 2, "burst_off2");
    push(4'b1111, 2'd3, 2, "burst_on3");
    push(4'b0000, 2'd3, 2, "burst_off3");
    push(4'b1111, 2'd3, 6, "burst_after_gap");
    push(4'b0000, 2'd3, 2, "burst_rep_off");
    push(4'b1111, 2'd3, 2, "burst_rep_on");
    issue(2'd3, 4'd0, 1'b0, 1'b0);
    mon_en = 1'b1;
    drain("burst");

    // valid held while not ready: second command (BLINK) must be ignored
    push(4'b0001, 2'd2, 0, "hs_apply");
    push(4'b0010, 2'd2, 2, "hs_s1");
    push(4'b0100, 2'd2, 2, "hs_s2");
    push(4'b1000, 2'd2, 2, "hs_s3");
    issue(2'd2, 4'd0, 1'b0, 1'b1);
    mon_en = 1'b1;
    chk("hs_ready_low", o_cmd_ready, 0);
    i_cmd_mode = 2'd1;
    adv(1);
    i_cmd_valid = 1'b0;
    chk("hs_mode_first", o_mode, 2);
    drain("hs");
    chk("hs_mode_kept", o_mode, 2);

    // acceptance on a tick cycle applies at the following tick
    issue(2'd1, 4'd0, 1'b1, 1'b0);
    chk("tickacc_ready0", o_cmd_ready, 0);
    chk("tickacc_mode0", o_mode, 2);
    chk("tickacc_onehot0", $countones(o_led), 1);
    adv(1);
    chk("tickacc_ready1", o_cmd_ready, 0);
    chk("tickacc_mode1", o_mode, 2);
    adv(1);
    chk("tickacc_ready2", o_cmd_ready, 1);
    chk("tickacc_mode2", o_mode, 1);
    chk("tickacc_led2", o_led, 4'b1111);

    // OFF holds all LEDs dark
    issue(2'd0, 4'd0, 1'b0, 1'b0);
    adv(1);
    chk("off_mode", o_mode, 0);
    chk("off_led", o_led, 0);
    adv(6);
    chk("off_hold", o_led, 0);

    // restart: re-issue BLINK rate 3 at step_cnt=1; toggle comes 4 ticks after the re-apply
    push(4'b1111, 2'd1, 0, "restart_apply");
    push(4'b0000, 2'd1, 12, "restart_toggle");
    issue(2'd1, 4'd3, 1'b0, 1'b0);
    mon_en = 1'b1;
    adv(1);
    chk("restart_led_first", o_led, 4'b1111);
    adv(2);
    issue(2'd1, 4'd3, 1'b0, 1'b0);
    chk("restart_ready_low", o_cmd_ready, 0);
    drain("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
